// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared width default, saturation bounds and state type for add_accum
package add_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } add_accum_state_t;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/add_sat_shift.sv
// rtl/add_sat_shift.sv - optional rounding (ADD_ACCUM_ROUND_EN), arithmetic shift and saturation
module add_sat_shift
    import add_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = DW_DEF + 3,
    parameter int OUT_SHIFT = 3
) (
    input  logic signed [AW-1:0] sum_i,
    output logic signed [DW-1:0] result_o,
    output logic                 ovf_o
);

    localparam logic signed [AW:0]   MAX_W = (AW+1)'(sat_max(DW));
    localparam logic signed [AW:0]   MIN_W = (AW+1)'(sat_min(DW));
    localparam logic signed [DW-1:0] MAX_D = DW'(sat_max(DW));
    localparam logic signed [DW-1:0] MIN_D = DW'(sat_min(DW));

    logic signed [AW:0] ext;
    logic signed [AW:0] rnd;
    logic signed [AW:0] shifted;

    // One guard bit so the rounding increment can never wrap.
    assign ext = {sum_i[AW-1], sum_i};

`ifdef ADD_ACCUM_ROUND_EN
    localparam logic signed [AW:0] RND = (AW+1)'((2 ** OUT_SHIFT) / 2);
    assign rnd = ext + RND;
`else
    assign rnd = ext;
`endif

    assign shifted = rnd >>> OUT_SHIFT;

    always_comb begin
        result_o = shifted[DW-1:0];
        ovf_o    = 1'b0;
        if (shifted > MAX_W) begin
            result_o = MAX_D;
            ovf_o    = 1'b1;
        end else if (shifted < MIN_W) begin
            result_o = MIN_D;
            ovf_o    = 1'b1;
        end
    end

endmodule

// File: rtl/add_accum.sv
// rtl/add_accum.sv - block accumulator of 2^LOG2_N samples with scaled saturated output
// Rounding before the shift is enabled by defining ADD_ACCUM_ROUND_EN.
module add_accum
    import add_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int LOG2_N    = 3,
    parameter int OUT_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 ovf,
    output logic                 busy
);

    localparam int                AW       = DW + LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'((2 ** LOG2_N) - 1);
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

    add_accum_state_t      state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [LOG2_N-1:0]     cnt_q, cnt_d;
    logic signed [DW-1:0]  dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  din_ready_q;
    logic signed [AW-1:0]  din_ext;
    logic signed [AW-1:0]  sum;
    logic signed [DW-1:0]  res;
    logic                  res_ovf;
    logic                  accept;

    assign din_ext = {{LOG2_N{din[DW-1]}}, din};
    assign sum     = acc_q + din_ext;
    assign accept  = din_valid && din_ready_q;

    add_sat_shift #(
        .DW        (DW),
        .AW        (AW),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_sat_shift (
        .sum_i    (sum),
        .result_o (res),
        .ovf_o    (res_ovf)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        ovf_d        = ovf_q;
        dout_valid_d = dout_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = din_ext;
                    cnt_d   = CNT_ONE;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        dout_d       = res;
                        ovf_d        = res_ovf;
                        dout_valid_d = 1'b1;
                        state_d      = OUT;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            OUT: begin
                if (dout_valid_q && dout_ready) begin
                    dout_valid_d = 1'b0;
                    acc_d        = '0;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // din_ready is registered so it stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            ovf_q        <= 1'b0;
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            ovf_q        <= ovf_d;
            dout_valid_q <= dout_valid_d;
            din_ready_q  <= (state_d != OUT);
        end
    end

    assign din_ready  = din_ready_q;
    assign dout       = dout_q;
    assign ovf        = ovf_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_add_accum.sv
// tb/tb_add_accum.sv - directed self-checking bench for add_accum
module tb_add_accum;

    logic               clk;
    logic               rst;
    logic signed [15:0] din;
    logic               din_valid;
    logic               dout_ready;

    logic               din_ready_a, dout_valid_a, ovf_a, busy_a;
    logic signed [15:0] dout_a;
    logic               din_ready_b, dout_valid_b, ovf_b, busy_b;
    logic signed [15:0] dout_b;

    int errors = 0;
    int checks = 0;
    int stalls;

    add_accum #(.DW(16), .LOG2_N(3), .OUT_SHIFT(3)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready_a),
        .dout       (dout_a),
        .dout_valid (dout_valid_a),
        .dout_ready (dout_ready),
        .ovf        (ovf_a),
        .busy       (busy_a)
    );

    // Same stimulus, no scaling: exercises saturation.
    add_accum #(.DW(16), .LOG2_N(3), .OUT_SHIFT(0)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready_b),
        .dout       (dout_b),
        .dout_valid (dout_valid_b),
        .dout_ready (dout_ready),
        .ovf        (ovf_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sample was accepted.
    task automatic push(input logic signed [15:0] v);
        int t;
        t = 0;
        din       = v;
        din_valid = 1'b1;
        while (!din_ready_a && t < 20) begin
            @(negedge clk);
            t++;
        end
        stalls += t;
        if (t >= 20) check("push_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic block(input logic signed [15:0] v);
        for (int i = 0; i < 8; i++) push(v);
        din_valid = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        stalls     = 0;

        #12;
        check("rst_dout", dout_a, 0);
        check("rst_dout_valid", dout_valid_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_din_ready", din_ready_a, 0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("din_ready_before_edge", din_ready_a, 0);
        @(negedge clk);
        check("din_ready_after_edge", din_ready_a, 1);

        // Eight samples of 100, valid held high.
        stalls = 0;
        block(16'sd100);
        check("t1_stalls", stalls, 0);
        check("t1_dout_valid", dout_valid_a, 1);
        check("t1_dout", dout_a, 100);
        check("t1_ovf", ovf_a, 0);
        check("t1_din_ready_out", din_ready_a, 0);
        check("t1_busy_out", busy_a, 1);
        drain();
        check("t1_dout_valid_1cyc", dout_valid_a, 0);
        check("t1_din_ready_idle", din_ready_a, 1);
        check("t1_busy_idle", busy_a, 0);

        // Samples 1..8, sum 36.
        for (int i = 1; i <= 8; i++) push(16'(i));
        din_valid = 1'b0;
        check("ramp_dout_valid", dout_valid_a, 1);
`ifdef ADD_ACCUM_ROUND_EN
        check("ramp_dout", dout_a, 5);
`else
        check("ramp_dout", dout_a, 4);
`endif
        check("ramp_nosat_b", dout_b, 36);
        drain();

        // Saturation with OUT_SHIFT=0.
        block(16'sd20000);
        check("sat_pos_dout", dout_b, 32767);
        check("sat_pos_ovf", ovf_b, 1);
        check("sat_pos_a", dout_a, 20000);
        check("sat_pos_a_ovf", ovf_a, 0);
        drain();
        block(-16'sd20000);
        check("sat_neg_dout", dout_b, -32768);
        check("sat_neg_ovf", ovf_b, 1);
        drain();
        block(16'sd4000);
        check("nosat_dout", dout_b, 32000);
        check("nosat_ovf", ovf_b, 0);
        drain();

        // Backpressure: held result, din offered but ignored.
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'sd10);
        din = 16'sd999;
        check("bp_dout_valid", dout_valid_a, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_dout_stable", dout_a, 10);
            check("bp_din_ready", din_ready_a, 0);
            check("bp_valid_held", dout_valid_a, 1);
            @(negedge clk);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake", dout_valid_a, 0);
        block(16'sd30);
        check("bp_next_valid", dout_valid_a, 1);
        check("bp_next_dout", dout_a, 30);
        drain();

        // din_valid toggled every other cycle.
        for (int i = 0; i < 8; i++) begin
            push(-16'sd7);
            if (i < 7) begin
                din_valid = 1'b0;
                check("tog_no_early_valid", dout_valid_a, 0);
                @(negedge clk);
            end
        end
        din_valid = 1'b0;
        check("tog_dout_valid", dout_valid_a, 1);
        check("tog_dout", dout_a, -7);
        check("tog_ovf", ovf_a, 0);
        drain();

        // Reset mid-block discards the partial sum.
        for (int i = 0; i < 5; i++) push(16'sd1000);
        din_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_dout", dout_a, 0);
        check("mid_rst_dout_valid", dout_valid_a, 0);
        check("mid_rst_ovf", ovf_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_din_ready", din_ready_a, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) push(16'sd50);
        check("post_rst_no_early", dout_valid_a, 0);
        push(16'sd50);
        din_valid = 1'b0;
        check("post_rst_valid", dout_valid_a, 1);
        check("post_rst_dout", dout_a, 50);
        check("post_rst_ovf", ovf_a, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
